// File: rtl/mux_pkg.sv
// Shared types and constants for the mux4 feed arbiter.
// DATA_W : width of each channel word (matches the mux in0..in3/out width)
// NCH    : channel count, tied to the 2-bit mux select
// SEL_W  : width of the mux select
package mux_pkg;

  localparam int unsigned DATA_W = 4;
  localparam int unsigned NCH    = 4;
  localparam int unsigned SEL_W  = 2;

  typedef logic [DATA_W-1:0] mux_word_t;
  typedef logic [SEL_W-1:0]  mux_sel_t;

  // Output side: EMPTY means out_valid=0, GRANTED means a word is presented.
  typedef enum logic [0:0] {
    StEmpty   = 1'b0,
    StGranted = 1'b1
  } out_state_e;

  // One-hot decode of a channel index.
  function automatic logic [NCH-1:0] sel_onehot(mux_sel_t s);
    logic [NCH-1:0] oh;
    oh    = '0;
    oh[s] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/mux_rr_pick.sv
// Rotating priority encoder used for round-robin arbitration.
// Searches req starting at ptr+1, ptr+2, ... wrapping mod 4, and returns the
// first set bit.
// Ports:
//   req  - request vector, bit i = channel i eligible
//   ptr  - last granted channel (search starts one above it)
//   any  - at least one request present
//   pick - chosen channel index (0 when any=0)
module mux_rr_pick
  import mux_pkg::*;
(
  input  logic [NCH-1:0] req,
  input  mux_sel_t       ptr,
  output logic           any,
  output mux_sel_t       pick
);

  logic found;

  always_comb begin
    any   = |req;
    pick  = '0;
    found = 1'b0;
    // Offsets 1..NCH; the 2-bit sum wraps naturally so offset NCH is ptr itself.
    for (int unsigned off = 1; off <= NCH; off++) begin
      if (!found && req[ptr + mux_sel_t'(off)]) begin
        found = 1'b1;
        pick  = ptr + mux_sel_t'(off);
      end
    end
  end

endmodule

// File: rtl/mux4_feed_arbiter.sv
// Upstream sequencer for the mux4to1 datapath.
// Buffers one word per input channel, round-robin arbitrates among buffered
// channels and drives the mux data inputs, select and an output qualifier.
// Ports:
//   clk, rst_n            - clock, synchronous active-low reset
//   in_valid/in_ready     - per-channel handshake (bit i = channel i)
//   in_data0..in_data3    - channel words
//   ch0..ch3              - holding registers, drive mux in0..in3
//   sel                   - registered grant, drives mux sel
//   out_valid/out_ready   - qualifier for the mux output word (ch[sel])
module mux4_feed_arbiter
  import mux_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NCH-1:0]    in_valid,
  output logic [NCH-1:0]    in_ready,
  input  logic [DATA_W-1:0] in_data0,
  input  logic [DATA_W-1:0] in_data1,
  input  logic [DATA_W-1:0] in_data2,
  input  logic [DATA_W-1:0] in_data3,
  output logic [DATA_W-1:0] ch0,
  output logic [DATA_W-1:0] ch1,
  output logic [DATA_W-1:0] ch2,
  output logic [DATA_W-1:0] ch3,
  output logic [SEL_W-1:0]  sel,
  output logic              out_valid,
  input  logic              out_ready
);

  out_state_e     state_q, state_d;
  logic [NCH-1:0] full_q, full_d;
  mux_word_t      ch_q [NCH];
  mux_word_t      ch_d [NCH];
  mux_sel_t       sel_q, sel_d;
  mux_sel_t       rr_ptr_q, rr_ptr_d;

  mux_word_t      in_data [NCH];
  logic [NCH-1:0] accept;
  logic [NCH-1:0] clr_mask;
  logic [NCH-1:0] elig;
  logic           consume;
  logic           elig_any;
  mux_sel_t       pick;

  assign in_data[0] = in_data0;
  assign in_data[1] = in_data1;
  assign in_data[2] = in_data2;
  assign in_data[3] = in_data3;

  // in_ready is a pure register decode: no path from in_valid or out_ready.
  assign in_ready  = ~full_q;
  assign out_valid = (state_q == StGranted);
  assign consume   = out_valid & out_ready;
  assign accept    = in_valid & in_ready;

  // The word being consumed this cycle cannot be granted again; a word
  // accepted this cycle is not yet in full_q, so it waits one cycle.
  assign clr_mask = consume ? sel_onehot(sel_q) : '0;
  assign elig     = full_q & ~clr_mask;

  mux_rr_pick u_rr_pick (
    .req  (elig),
    .ptr  (rr_ptr_q),
    .any  (elig_any),
    .pick (pick)
  );

  // Holding registers and full flags. A channel is only written while empty,
  // so ch[sel] stays stable under backpressure.
  always_comb begin
    full_d = (full_q & ~clr_mask) | accept;
    for (int unsigned i = 0; i < NCH; i++) begin
      ch_d[i] = accept[i] ? in_data[i] : ch_q[i];
    end
  end

  // Output FSM next-state.
  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    rr_ptr_d = rr_ptr_q;
    unique case (state_q)
      StEmpty: begin
        if (elig_any) begin
          state_d  = StGranted;
          sel_d    = pick;
          rr_ptr_d = pick;
        end
      end
      StGranted: begin
        if (out_ready) begin
          if (elig_any) begin
            // Back-to-back grant in the same cycle as the consume.
            sel_d    = pick;
            rr_ptr_d = pick;
          end else begin
            state_d = StEmpty;
          end
        end
      end
      default: state_d = StEmpty;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StEmpty;
      full_q   <= '0;
      sel_q    <= '0;
      // Pointer at the last channel so channel 0 wins the first grant.
      rr_ptr_q <= mux_sel_t'(NCH - 1);
      for (int unsigned i = 0; i < NCH; i++) begin
        ch_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      full_q   <= full_d;
      sel_q    <= sel_d;
      rr_ptr_q <= rr_ptr_d;
      for (int unsigned i = 0; i < NCH; i++) begin
        ch_q[i] <= ch_d[i];
      end
    end
  end

  assign ch0 = ch_q[0];
  assign ch1 = ch_q[1];
  assign ch2 = ch_q[2];
  assign ch3 = ch_q[3];
  assign sel = sel_q;

endmodule
